// File: rtl/lieat_exu_fpu_wbq.sv
// rtl/lieat_exu_fpu_wbq.sv - FPU writeback queue with pending-destination hazard lookup
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_exu_fpu_wbq #(
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush_req,
    input  logic                      wbq_i_valid,
    output logic                      wbq_i_ready,
    input  logic [`XLEN-1:0]          wbq_i_pc,
    input  logic                      wbq_i_wen,
    input  logic [`REG_IDX-1:0]       wbq_i_rd,
    input  logic [`XLEN-1:0]          wbq_i_data,
    output logic                      wbq_o_valid,
    input  logic                      wbq_o_ready,
    output logic [`XLEN-1:0]          wbq_o_pc,
    output logic                      wbq_o_wen,
    output logic [`REG_IDX-1:0]       wbq_o_rd,
    output logic [`XLEN-1:0]          wbq_o_data,
    output logic [$clog2(DEPTH):0]    wbq_count,
    input  logic [`REG_IDX-1:0]       hzd_rs1,
    input  logic [`REG_IDX-1:0]       hzd_rs2,
    output logic                      hzd_rs1_hit,
    output logic                      hzd_rs2_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [`XLEN-1:0]    pc_q   [DEPTH];
    logic [`XLEN-1:0]    data_q [DEPTH];
    logic [`REG_IDX-1:0] rd_q   [DEPTH];
    logic [DEPTH-1:0]    wen_q;
    logic [DEPTH-1:0]    vld_q;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic enq;
    logic deq;
    logic rs1_match;
    logic rs2_match;

    // Ready and valid come only from registered occupancy, so a full queue
    // never accepts even when the head drains in the same cycle.
    assign wbq_i_ready = (count != CW'(DEPTH));
    assign wbq_o_valid = (count != '0);
    assign enq         = wbq_i_valid & wbq_i_ready;
    assign deq         = wbq_o_valid & wbq_o_ready;

    assign wbq_o_pc   = pc_q[rd_ptr];
    assign wbq_o_wen  = wen_q[rd_ptr];
    assign wbq_o_rd   = rd_q[rd_ptr];
    assign wbq_o_data = data_q[rd_ptr];
    assign wbq_count  = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= '0;
            wen_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else if (flush_req) begin
            // Payload fields are left stale; only bookkeeping is dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= '0;
        end else begin
            if (enq) begin
                pc_q[wr_ptr]   <= wbq_i_pc;
                data_q[wr_ptr] <= wbq_i_data;
                rd_q[wr_ptr]   <= wbq_i_rd;
                wen_q[wr_ptr]  <= wbq_i_wen;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Only committed entries are searched; the in-flight input is not.
    always_comb begin
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && wen_q[i] && (rd_q[i] == hzd_rs1)) rs1_match = 1'b1;
            if (vld_q[i] && wen_q[i] && (rd_q[i] == hzd_rs2)) rs2_match = 1'b1;
        end
    end

    assign hzd_rs1_hit = rs1_match & (hzd_rs1 != '0);
    assign hzd_rs2_hit = rs2_match & (hzd_rs2 != '0);

endmodule

// File: tb/tb_lieat_exu_fpu_wbq.sv
// tb/tb_lieat_exu_fpu_wbq.sv - directed table, random model and corner sequences for the FPU writeback queue
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module tb_lieat_exu_fpu_wbq;

    localparam int DEPTH = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush_req;
    logic                   wbq_i_valid;
    logic                   wbq_i_ready;
    logic [`XLEN-1:0]       wbq_i_pc;
    logic                   wbq_i_wen;
    logic [`REG_IDX-1:0]    wbq_i_rd;
    logic [`XLEN-1:0]       wbq_i_data;
    logic                   wbq_o_valid;
    logic                   wbq_o_ready;
    logic [`XLEN-1:0]       wbq_o_pc;
    logic                   wbq_o_wen;
    logic [`REG_IDX-1:0]    wbq_o_rd;
    logic [`XLEN-1:0]       wbq_o_data;
    logic [$clog2(DEPTH):0] wbq_count;
    logic [`REG_IDX-1:0]    hzd_rs1;
    logic [`REG_IDX-1:0]    hzd_rs2;
    logic                   hzd_rs1_hit;
    logic                   hzd_rs2_hit;

    lieat_exu_fpu_wbq #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush_req(flush_req),
        .wbq_i_valid(wbq_i_valid), .wbq_i_ready(wbq_i_ready),
        .wbq_i_pc(wbq_i_pc), .wbq_i_wen(wbq_i_wen), .wbq_i_rd(wbq_i_rd), .wbq_i_data(wbq_i_data),
        .wbq_o_valid(wbq_o_valid), .wbq_o_ready(wbq_o_ready),
        .wbq_o_pc(wbq_o_pc), .wbq_o_wen(wbq_o_wen), .wbq_o_rd(wbq_o_rd), .wbq_o_data(wbq_o_data),
        .wbq_count(wbq_count),
        .hzd_rs1(hzd_rs1), .hzd_rs2(hzd_rs2),
        .hzd_rs1_hit(hzd_rs1_hit), .hzd_rs2_hit(hzd_rs2_hit)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic                v, rdy, fl, wen;
        logic [`REG_IDX-1:0] rd;
        logic [`XLEN-1:0]    data;
        logic [`REG_IDX-1:0] rs1, rs2;
        logic                ov, ir;
        int                  cnt;
        logic                h1, h2, owen;
        logic [`REG_IDX-1:0] ord;
        logic [`XLEN-1:0]    odata;
    } vec_t;

    typedef struct {
        logic [`XLEN-1:0]    pc;
        logic                wen;
        logic [`REG_IDX-1:0] rd;
        logic [`XLEN-1:0]    data;
    } ent_t;

    localparam logic [`XLEN-1:0] ONE_F = 32'h3F80_0000;

    function automatic logic [`XLEN-1:0] pc_of(input logic [`XLEN-1:0] d);
        return (d == ONE_F) ? 32'h100 : 32'h200 + 4 * d;
    endfunction

    function automatic vec_t mk(input logic v, rdy, fl, wen, input int rd, input logic [31:0] data,
                                input int rs1, rs2, input logic ov, ir, input int cnt,
                                input logic h1, h2, owen, input int ord, input logic [31:0] odata);
        vec_t t;
        t.v = v; t.rdy = rdy; t.fl = fl; t.wen = wen; t.rd = rd[4:0]; t.data = data;
        t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.ov = ov; t.ir = ir; t.cnt = cnt;
        t.h1 = h1; t.h2 = h2; t.owen = owen; t.ord = ord[4:0]; t.odata = odata;
        return t;
    endfunction

    vec_t tbl[16];
    ent_t q[$];
    ent_t e;
    logic mv, mr, mf;
    logic xh1, xh2;
    int got, sent;
    bit do_enq, do_deq;

    initial begin
        // v rdy fl wen rd data rs1 rs2 | ov ir cnt h1 h2 owen ord odata
        tbl[0]  = mk(1,0,0,1, 5, ONE_F, 5,0, 1,1,1, 1,0,1, 5, ONE_F);
        tbl[1]  = mk(0,0,0,0, 0, 0,     0,5, 1,1,1, 0,1,1, 5, ONE_F);
        tbl[2]  = mk(1,0,0,1, 6, 1,     6,7, 1,1,2, 1,0,1, 5, ONE_F);
        tbl[3]  = mk(1,0,0,0, 7, 2,     7,7, 1,1,3, 0,0,1, 5, ONE_F);
        tbl[4]  = mk(1,0,0,1, 8, 3,     8,6, 1,0,4, 1,1,1, 5, ONE_F);
        tbl[5]  = mk(1,1,0,1, 9, 4,     9,5, 1,1,3, 0,0,1, 6, 1);
        tbl[6]  = mk(1,1,0,1,10, 5,    10,6, 1,1,3, 1,0,0, 7, 2);
        tbl[7]  = mk(1,1,0,1,11, 6,    11,7, 1,1,3, 1,0,1, 8, 3);
        tbl[8]  = mk(1,1,1,1, 4, 7,     8,4, 0,1,0, 0,0,1,10, 5);
        tbl[9]  = mk(0,0,0,0, 0, 0,    10,11,0,1,0, 0,0,1,10, 5);
        tbl[10] = mk(1,1,0,1, 1, 8,     1,0, 1,1,1, 1,0,1, 1, 8);
        tbl[11] = mk(1,0,0,1, 2, 9,     2,1, 1,1,2, 1,1,1, 1, 8);
        tbl[12] = mk(1,1,0,1, 3, 10,    1,3, 1,1,2, 0,1,1, 2, 9);
        tbl[13] = mk(1,1,0,1, 4, 11,    4,2, 1,1,2, 1,0,1, 3, 10);
        tbl[14] = mk(0,1,0,0, 0, 0,     4,3, 1,1,1, 1,0,1, 4, 11);
        tbl[15] = mk(0,1,0,0, 0, 0,     4,0, 0,1,0, 0,0,1, 1, 8);

        reset = 1; flush_req = 0; wbq_i_valid = 0; wbq_o_ready = 0;
        wbq_i_pc = 0; wbq_i_wen = 0; wbq_i_rd = 0; wbq_i_data = 0; hzd_rs1 = 0; hzd_rs2 = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0; hzd_rs1 = 5; hzd_rs2 = 0;
        #1;
        chk("rst_ovalid", wbq_o_valid, 0);
        chk("rst_iready", wbq_i_ready, 1);
        chk("rst_count", wbq_count, 0);
        chk("rst_opc", wbq_o_pc, 0);
        chk("rst_ord", wbq_o_rd, 0);
        chk("rst_owen", wbq_o_wen, 0);
        chk("rst_odata", wbq_o_data, 0);
        chk("rst_hit1", hzd_rs1_hit, 0);
        chk("rst_hit2", hzd_rs2_hit, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            wbq_i_valid = tbl[i].v; wbq_o_ready = tbl[i].rdy; flush_req = tbl[i].fl;
            wbq_i_wen = tbl[i].wen; wbq_i_rd = tbl[i].rd; wbq_i_data = tbl[i].data;
            wbq_i_pc = pc_of(tbl[i].data);
            hzd_rs1 = tbl[i].rs1; hzd_rs2 = tbl[i].rs2;
            @(posedge clock);
            #1;
            chk($sformatf("t%0d_ovalid", i), wbq_o_valid, tbl[i].ov);
            chk($sformatf("t%0d_iready", i), wbq_i_ready, tbl[i].ir);
            chk($sformatf("t%0d_count", i), wbq_count, tbl[i].cnt);
            chk($sformatf("t%0d_hit1", i), hzd_rs1_hit, tbl[i].h1);
            chk($sformatf("t%0d_hit2", i), hzd_rs2_hit, tbl[i].h2);
            chk($sformatf("t%0d_owen", i), wbq_o_wen, tbl[i].owen);
            chk($sformatf("t%0d_ord", i), wbq_o_rd, tbl[i].ord);
            chk($sformatf("t%0d_odata", i), wbq_o_data, tbl[i].odata);
            chk($sformatf("t%0d_opc", i), wbq_o_pc, pc_of(tbl[i].odata));
        end

        // Stream 10 entries with random backpressure; they must drain in order.
        got = 0; sent = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            flush_req = 0;
            wbq_i_valid = (sent < 10); wbq_i_data = sent; wbq_i_pc = pc_of(sent);
            wbq_i_rd = 5'd3; wbq_i_wen = 1;
            wbq_o_ready = $urandom_range(0, 1);
            #1;
            if (wbq_o_valid && wbq_o_ready) begin
                chk("stream_order", wbq_o_data, got);
                got++;
            end
            if (wbq_i_valid && wbq_i_ready) sent++;
            @(posedge clock);
            if (got == 10) break;
        end
        #1;
        chk("stream_done", got, 10);
        chk("stream_count", wbq_count, 0);

        // Random traffic against a queue model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            mv = $urandom_range(0, 1); mr = $urandom_range(0, 2) != 0;
            mf = $urandom_range(0, 40) == 0;
            e.pc = $urandom; e.wen = $urandom_range(0, 3) != 0;
            e.rd = $urandom_range(0, 7); e.data = $urandom;
            wbq_i_valid = mv; wbq_o_ready = mr; flush_req = mf;
            wbq_i_pc = e.pc; wbq_i_wen = e.wen; wbq_i_rd = e.rd; wbq_i_data = e.data;
            hzd_rs1 = $urandom_range(0, 7); hzd_rs2 = $urandom_range(0, 7);
            @(posedge clock);
            if (mf) q.delete();
            else begin
                do_deq = (q.size() > 0) && mr;
                do_enq = (q.size() < DEPTH) && mv;
                if (do_deq) void'(q.pop_front());
                if (do_enq) q.push_back(e);
            end
            xh1 = 0; xh2 = 0;
            foreach (q[k]) begin
                if (q[k].wen && q[k].rd == hzd_rs1 && hzd_rs1 != 0) xh1 = 1;
                if (q[k].wen && q[k].rd == hzd_rs2 && hzd_rs2 != 0) xh2 = 1;
            end
            #1;
            chk("rnd_count", wbq_count, q.size());
            chk("rnd_ovalid", wbq_o_valid, q.size() != 0);
            chk("rnd_iready", wbq_i_ready, q.size() != DEPTH);
            chk("rnd_hit1", hzd_rs1_hit, xh1);
            chk("rnd_hit2", hzd_rs2_hit, xh2);
            if (q.size() != 0) begin
                chk("rnd_opc", wbq_o_pc, q[0].pc);
                chk("rnd_owen", wbq_o_wen, q[0].wen);
                chk("rnd_ord", wbq_o_rd, q[0].rd);
                chk("rnd_odata", wbq_o_data, q[0].data);
            end
        end

        // Reset mid-operation outranks a concurrent push and clears storage.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            flush_req = 0; wbq_o_ready = 0; wbq_i_valid = 1;
            wbq_i_pc = 32'h400 + i; wbq_i_wen = 1; wbq_i_rd = 5'd9; wbq_i_data = 32'hABC0 + i;
            @(posedge clock);
        end
        @(negedge clock);
        reset = 1; flush_req = 1; wbq_o_ready = 1; hzd_rs1 = 9; hzd_rs2 = 9;
        @(posedge clock);
        #1;
        chk("mrst_count", wbq_count, 0);
        chk("mrst_ovalid", wbq_o_valid, 0);
        chk("mrst_odata", wbq_o_data, 0);
        chk("mrst_opc", wbq_o_pc, 0);
        chk("mrst_hit1", hzd_rs1_hit, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
